// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory port seen by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic              c_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_done,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_done,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the CPU (c_*)
// and the loader/DMA (d_*); one access in flight at a time, req/done handshakes.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic              grant, grant_d;
  logic              last_owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
  logic [3:0]        cnt;

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.c_req || bus.d_req) begin
          grant = 1'b1;
          // On a tie the port that was not served last wins.
          grant_d  = bus.d_req && (!bus.c_req || !last_owner);
          state_nx = ISSUE;
        end
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner   <= grant_d;
        we_q    <= grant_d ? bus.d_we    : bus.c_we;
        addr_q  <= grant_d ? bus.d_addr  : bus.c_addr;
        wdata_q <= grant_d ? bus.d_wdata : bus.c_wdata;
      end
      if (state == ISSUE) cnt <= 4'(MEM_LAT - 1);
      if (state == WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!we_q) begin
          if (owner) d_rdata_q <= bus.m_rdata;
          else       c_rdata_q <= bus.m_rdata;
        end
      end
      if (state == DONE) last_owner <= owner;
    end
  end

  assign bus.m_en    = (state == ISSUE);
  assign bus.m_we    = (state == ISSUE) && we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.c_done  = (state == DONE) && !owner;
  assign bus.d_done  = (state == DONE) && owner;
  assign busy        = (state != IDLE);

endmodule
